// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter: shares one slave-side bus between M0 and M1.
// Bursts are never split; data-phase ownership steers HWDATA and HREADY.
//
// Ports:
//   HCLK, HRESET          clock, asynchronous active-high reset
//   M0_* / M1_*           master address/control/write-data inputs
//   M0_HREADY, M1_HREADY  per-master ready (low = stalled or waiting)
//   M_HRDATA              read data broadcast to both masters
//   S_*                   slave-side address/control/write data outputs
//   S_HREADY, S_HRDATA    slave-side ready and read data
//   GNT                   one-hot address-phase owner, 00 = none
module ahb_lite_arbiter2 #(
    parameter int FIXED_PRIO = 0,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic [DW-1:0] M_HRDATA,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [DW-1:0] S_HWDATA,
    input  logic          S_HREADY,
    input  logic [DW-1:0] S_HRDATA,
    output logic [1:0]    GNT
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t     sel;
    owner_t     sel_q;
    owner_t     dp;
    owner_t     rr_pick;
    logic       last;     // 0 = M0 won last NONSEQ, 1 = M1
    logic       lock;
    logic       req0;
    logic       req1;
    logic [1:0] sel_trans;
    logic [1:0] q_trans;

    assign req0 = M0_HTRANS[1];
    assign req1 = M1_HTRANS[1];

    // Transfer type currently presented by the selected master
    always_comb begin
        sel_trans = TR_IDLE;
        unique case (sel)
            OWN_M0:  sel_trans = M0_HTRANS;
            OWN_M1:  sel_trans = M1_HTRANS;
            default: sel_trans = TR_IDLE;
        endcase
    end

    // Transfer type presented by last cycle's owner
    always_comb begin
        q_trans = TR_IDLE;
        unique case (sel_q)
            OWN_M0:  q_trans = M0_HTRANS;
            OWN_M1:  q_trans = M1_HTRANS;
            default: q_trans = TR_IDLE;
        endcase
    end

    assign rr_pick = last ? OWN_M0 : OWN_M1;

    // Address-phase selection. A locked owner keeps the bus only while it
    // continues its burst (SEQ or BUSY, both have bit 0 set); IDLE or a
    // fresh NONSEQ hands the decision back to arbitration.
    always_comb begin
        sel = OWN_NONE;
        if (HRESET) begin
            sel = OWN_NONE;
        end else if (!S_HREADY) begin
            sel = sel_q;
        end else if (lock && q_trans[0]) begin
            sel = sel_q;
        end else if (req0 && req1) begin
            sel = (FIXED_PRIO != 0) ? OWN_M0 : rr_pick;
        end else if (req0) begin
            sel = OWN_M0;
        end else if (req1) begin
            sel = OWN_M1;
        end else begin
            sel = OWN_NONE;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= OWN_NONE;
            dp    <= OWN_NONE;
            last  <= 1'b1;
            lock  <= 1'b0;
        end else begin
            sel_q <= sel;
            if (S_HREADY) begin
                if (sel != OWN_NONE && sel_trans[1]) begin
                    dp <= sel;
                end else begin
                    dp <= OWN_NONE;
                end
                if (sel != OWN_NONE && sel_trans == TR_NONSEQ) begin
                    last <= (sel == OWN_M1);
                end
                // BUSY inside a burst keeps the bus held
                lock <= (sel != OWN_NONE) &&
                        (sel_trans[1] || (sel_trans == TR_BUSY && lock));
            end
        end
    end

    // Slave-side address/control mux
    always_comb begin
        S_HADDR  = '0;
        S_HTRANS = TR_IDLE;
        S_HWRITE = 1'b0;
        S_HSIZE  = 3'b000;
        unique case (sel)
            OWN_M0: begin
                S_HADDR  = M0_HADDR;
                S_HTRANS = M0_HTRANS;
                S_HWRITE = M0_HWRITE;
                S_HSIZE  = M0_HSIZE;
            end
            OWN_M1: begin
                S_HADDR  = M1_HADDR;
                S_HTRANS = M1_HTRANS;
                S_HWRITE = M1_HWRITE;
                S_HSIZE  = M1_HSIZE;
            end
            default: begin
                S_HADDR  = '0;
                S_HTRANS = TR_IDLE;
                S_HWRITE = 1'b0;
                S_HSIZE  = 3'b000;
            end
        endcase
    end

    // Write data follows the data-phase owner, not the address owner
    always_comb begin
        S_HWDATA = '0;
        unique case (dp)
            OWN_M0:  S_HWDATA = M0_HWDATA;
            OWN_M1:  S_HWDATA = M1_HWDATA;
            default: S_HWDATA = '0;
        endcase
    end

    assign GNT      = {sel == OWN_M1, sel == OWN_M0};
    assign M_HRDATA = S_HRDATA;

    // A master in its data phase waits on the slave; a master only in
    // its address phase waits until it is granted with the bus free.
    always_comb begin
        if (HRESET) begin
            M0_HREADY = 1'b1;
        end else if (dp == OWN_M0) begin
            M0_HREADY = S_HREADY & (~req0 | (sel == OWN_M0));
        end else begin
            M0_HREADY = ~req0 | ((sel == OWN_M0) & S_HREADY);
        end
    end

    always_comb begin
        if (HRESET) begin
            M1_HREADY = 1'b1;
        end else if (dp == OWN_M1) begin
            M1_HREADY = S_HREADY & (~req1 | (sel == OWN_M1));
        end else begin
            M1_HREADY = ~req1 | ((sel == OWN_M1) & S_HREADY);
        end
    end

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Bench for ahb_lite_arbiter2: round-robin and fixed-priority instances
// share one stimulus stream and are compared against a transaction model.
module tb_ahb_lite_arbiter2;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] m0_addr, m1_addr;
    logic [1:0]  m0_trans, m1_trans;
    logic        m0_write, m1_write;
    logic [2:0]  m0_size, m1_size;
    logic [31:0] m0_wdata, m1_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        m0_hready [2];
    logic        m1_hready [2];
    logic [31:0] m_hrdata  [2];
    logic [31:0] s_haddr   [2];
    logic [1:0]  s_htrans  [2];
    logic        s_hwrite  [2];
    logic [2:0]  s_hsize   [2];
    logic [31:0] s_hwdata  [2];
    logic [1:0]  gnt       [2];

    int passed = 0;
    int total  = 0;

    // model: bus owner, data-phase owner, last NONSEQ winner (-1 = none)
    int own [2];
    int dpo [2];
    int lastw [2];
    int selc [2];
    bit lk [2];

    always #5 hclk = ~hclk;

    ahb_lite_arbiter2 #(.FIXED_PRIO(0), .AW(32), .DW(32)) dut_rr (
        .HCLK(hclk), .HRESET(hreset),
        .M0_HADDR(m0_addr), .M0_HTRANS(m0_trans), .M0_HWRITE(m0_write),
        .M0_HSIZE(m0_size), .M0_HWDATA(m0_wdata), .M0_HREADY(m0_hready[0]),
        .M1_HADDR(m1_addr), .M1_HTRANS(m1_trans), .M1_HWRITE(m1_write),
        .M1_HSIZE(m1_size), .M1_HWDATA(m1_wdata), .M1_HREADY(m1_hready[0]),
        .M_HRDATA(m_hrdata[0]),
        .S_HADDR(s_haddr[0]), .S_HTRANS(s_htrans[0]), .S_HWRITE(s_hwrite[0]),
        .S_HSIZE(s_hsize[0]), .S_HWDATA(s_hwdata[0]),
        .S_HREADY(s_ready), .S_HRDATA(s_rdata), .GNT(gnt[0])
    );

    ahb_lite_arbiter2 #(.FIXED_PRIO(1), .AW(32), .DW(32)) dut_fp (
        .HCLK(hclk), .HRESET(hreset),
        .M0_HADDR(m0_addr), .M0_HTRANS(m0_trans), .M0_HWRITE(m0_write),
        .M0_HSIZE(m0_size), .M0_HWDATA(m0_wdata), .M0_HREADY(m0_hready[1]),
        .M1_HADDR(m1_addr), .M1_HTRANS(m1_trans), .M1_HWRITE(m1_write),
        .M1_HSIZE(m1_size), .M1_HWDATA(m1_wdata), .M1_HREADY(m1_hready[1]),
        .M_HRDATA(m_hrdata[1]),
        .S_HADDR(s_haddr[1]), .S_HTRANS(s_htrans[1]), .S_HWRITE(s_hwrite[1]),
        .S_HSIZE(s_hsize[1]), .S_HWDATA(s_hwdata[1]),
        .S_HREADY(s_ready), .S_HRDATA(s_rdata), .GNT(gnt[1])
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] tr(int x);
        return (x == 0) ? m0_trans : m1_trans;
    endfunction

    // Who owns the address phase this cycle, from the arbitration rules
    function automatic int pick(int m);
        logic [1:0] t;
        if (!s_ready) return own[m];
        if (lk[m] && own[m] >= 0) begin
            t = tr(own[m]);
            if (t == 2'b11 || t == 2'b01) return own[m];
        end
        if (m0_trans[1] && m1_trans[1]) begin
            if (m == 1) return 0;
            return (lastw[m] == 0) ? 1 : 0;
        end
        if (m0_trans[1]) return 0;
        if (m1_trans[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m]   = -1;
            dpo[m]   = -1;
            lastw[m] = 1;
            lk[m]    = 1'b0;
        end
    endtask

    task automatic settle();
        #3;
        for (int m = 0; m < 2; m++) begin
            int s;
            logic [1:0] eg;
            logic [1:0] et;
            logic [31:0] ea, ew;
            logic ewr, r0, r1, h0, h1;
            logic [2:0] es;
            string p;
            s = pick(m);
            selc[m] = s;
            p = (m == 0) ? "rr" : "fp";
            eg = (s == 0) ? 2'b01 : (s == 1) ? 2'b10 : 2'b00;
            et = (s < 0) ? 2'b00 : tr(s);
            ea = (s == 0) ? m0_addr : (s == 1) ? m1_addr : 32'h0;
            ewr = (s == 0) ? m0_write : (s == 1) ? m1_write : 1'b0;
            es = (s == 0) ? m0_size : (s == 1) ? m1_size : 3'b000;
            ew = (dpo[m] == 0) ? m0_wdata :
                 (dpo[m] == 1) ? m1_wdata : 32'h0;
            r0 = m0_trans[1];
            r1 = m1_trans[1];
            if (dpo[m] == 0) h0 = s_ready && (!r0 || s == 0);
            else h0 = !r0 || (s == 0 && s_ready);
            if (dpo[m] == 1) h1 = s_ready && (!r1 || s == 1);
            else h1 = !r1 || (s == 1 && s_ready);
            chk({p, "_gnt"}, gnt[m], eg);
            chk({p, "_htrans"}, s_htrans[m], et);
            chk({p, "_haddr"}, s_haddr[m], ea);
            chk({p, "_hwrite"}, s_hwrite[m], ewr);
            chk({p, "_hsize"}, s_hsize[m], es);
            chk({p, "_hwdata"}, s_hwdata[m], ew);
            chk({p, "_m0_hready"}, m0_hready[m], h0);
            chk({p, "_m1_hready"}, m1_hready[m], h1);
            chk({p, "_hrdata"}, m_hrdata[m], s_rdata);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        for (int m = 0; m < 2; m++) begin
            int s;
            logic [1:0] t;
            bit nlk;
            s = selc[m];
            own[m] = s;
            if (s_ready) begin
                t = (s < 0) ? 2'b00 : tr(s);
                if (s >= 0 && t == 2'b10) lastw[m] = s;
                nlk = (s >= 0) && (t[1] || (t == 2'b01 && lk[m]));
                dpo[m] = (s >= 0 && t[1]) ? s : -1;
                lk[m] = nlk;
            end
        end
        #1;
    endtask

    task automatic rst_chk(string p);
        for (int m = 0; m < 2; m++) begin
            chk({p, "_gnt"}, gnt[m], 2'b00);
            chk({p, "_htrans"}, s_htrans[m], 2'b00);
            chk({p, "_m0_hready"}, m0_hready[m], 1'b1);
            chk({p, "_m1_hready"}, m1_hready[m], 1'b1);
            chk({p, "_hwdata"}, s_hwdata[m], 32'h0);
        end
    endtask

    task automatic idle_all();
        m0_trans = 2'b00; m1_trans = 2'b00;
        m0_addr = 0; m1_addr = 0;
        m0_write = 0; m1_write = 0;
        m0_size = 3'd2; m1_size = 3'd2;
        m0_wdata = 0; m1_wdata = 0;
    endtask

    initial begin
        hreset = 1'b1;
        s_ready = 1'b1;
        s_rdata = 32'h0;
        idle_all();
        model_reset();
        #3;
        rst_chk("reset");
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        // contention: both issue single NONSEQs every cycle
        m0_trans = 2'b10; m0_addr = 32'h0000_1000;
        m1_trans = 2'b10; m1_addr = 32'h0000_2000;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("rr_order", gnt[0], (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c % 2 == 0) chk("rr_loser_m1", m1_hready[0], 1'b0);
            else chk("rr_loser_m0", m0_hready[0], 1'b0);
            chk("fp_gnt", gnt[1], 2'b01);
            chk("fp_m1_starve", m1_hready[1], 1'b0);
            tick();
        end
        idle_all();
        settle();
        tick();

        // M0 single write
        m0_trans = 2'b10; m0_addr = 32'h4000_0000; m0_write = 1'b1;
        settle();
        chk("wr_addr", s_haddr[0], 32'h4000_0000);
        chk("wr_ready0", m0_hready[0], 1'b1);
        tick();
        m0_trans = 2'b00; m0_wdata = 32'h1234_5678;
        settle();
        chk("wr_data", s_hwdata[0], 32'h1234_5678);
        chk("wr_ready1", m0_hready[0], 1'b1);
        tick();
        idle_all();

        // M1 4-beat INCR burst, M0 asks at beat 2
        for (int b = 0; b < 5; b++) begin
            m1_trans = (b == 0) ? 2'b10 : (b < 4) ? 2'b11 : 2'b00;
            m1_addr = 32'h0000_3000 + 32'(4 * b);
            if (b >= 1) begin
                m0_trans = 2'b10; m0_addr = 32'h0000_5000;
            end
            settle();
            if (b < 4) chk("burst_gnt", gnt[0], 2'b10);
            if (b >= 1 && b < 4) chk("burst_m0_wait", m0_hready[0], 1'b0);
            if (b == 4) begin
                chk("burst_m0_gnt", gnt[0], 2'b01);
                chk("burst_m0_rdy", m0_hready[0], 1'b1);
            end
            tick();
        end
        idle_all();
        settle();
        tick();

        // M0 read with 2 wait states while M1 requests
        m0_trans = 2'b10; m0_addr = 32'h0000_6000;
        settle();
        tick();
        m0_trans = 2'b00;
        m1_trans = 2'b10; m1_addr = 32'h0000_7000; m1_write = 1'b1;
        s_ready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            settle();
            chk("ws_gnt_hold", gnt[0], 2'b01);
            chk("ws_m0_wait", m0_hready[0], 1'b0);
            chk("ws_m1_wait", m1_hready[0], 1'b0);
            tick();
        end
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        settle();
        chk("ws_rdata", m_hrdata[0], 32'hCAFE_F00D);
        chk("ws_m0_done", m0_hready[0], 1'b1);
        chk("ws_m1_gnt", gnt[0], 2'b10);
        tick();

        // reset mid data phase of M1 while the slave stalls
        m1_trans = 2'b00; m1_wdata = 32'h0BAD_0BAD;
        s_ready = 1'b0;
        settle();
        chk("pre_rst_wdata", s_hwdata[0], 32'h0BAD_0BAD);
        hreset = 1'b1;
        s_ready = 1'b1;
        m0_trans = 2'b10; m0_addr = 32'h0000_8000;
        #1;
        rst_chk("midrst");
        model_reset();
        @(posedge hclk);
        @(posedge hclk);
        #1;
        idle_all();
        hreset = 1'b0;

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            m0_trans = 2'($urandom_range(0, 3));
            m1_trans = 2'($urandom_range(0, 3));
            m0_addr = $urandom; m1_addr = $urandom;
            m0_write = 1'($urandom_range(0, 1));
            m1_write = 1'($urandom_range(0, 1));
            m0_size = 3'($urandom_range(0, 2));
            m1_size = 3'($urandom_range(0, 2));
            m0_wdata = $urandom; m1_wdata = $urandom;
            s_ready = ($urandom_range(0, 3) != 0);
            s_rdata = $urandom;
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
